// File: rtl/uart_probe_pkg.sv
// uart_probe_pkg: command codes, FSM states and control-register bit positions shared by the probe.
package uart_probe_pkg;

    localparam logic [7:0] CMD_GPI_RD0 = 8'd2;
    localparam logic [7:0] CMD_GPI_RD1 = 8'd3;
    localparam logic [7:0] CMD_GPI_RD2 = 8'd4;
    localparam logic [7:0] CMD_GPI_RD3 = 8'd5;
    localparam logic [7:0] CMD_GPO_RD0 = 8'd6;
    localparam logic [7:0] CMD_GPO_RD1 = 8'd7;
    localparam logic [7:0] CMD_GPO_RD2 = 8'd8;
    localparam logic [7:0] CMD_GPO_RD3 = 8'd9;
    localparam logic [7:0] CMD_GPO_WR0 = 8'd10;
    localparam logic [7:0] CMD_GPO_WR1 = 8'd11;
    localparam logic [7:0] CMD_GPO_WR2 = 8'd12;
    localparam logic [7:0] CMD_GPO_WR3 = 8'd13;
    localparam logic [7:0] CMD_AXI_RD0 = 8'd14;
    localparam logic [7:0] CMD_AXI_RD1 = 8'd15;
    localparam logic [7:0] CMD_AXI_RD2 = 8'd16;
    localparam logic [7:0] CMD_AXI_RD3 = 8'd17;
    localparam logic [7:0] CMD_AXI_WR0 = 8'd18;
    localparam logic [7:0] CMD_AXI_WR1 = 8'd19;
    localparam logic [7:0] CMD_AXI_WR2 = 8'd20;
    localparam logic [7:0] CMD_AXI_WR3 = 8'd21;
    localparam logic [7:0] CMD_AXI_RD  = 8'd22;
    localparam logic [7:0] CMD_AXI_WR  = 8'd23;
    localparam logic [7:0] CMD_AXI_RDC = 8'd24;
    localparam logic [7:0] CMD_AXI_WRC = 8'd25;

    localparam int CTRL_AUTO_INC = 0;
    localparam int CTRL_RESP_LO  = 2;
    localparam int CTRL_RESP_HI  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG,
        ST_RESP,
        ST_AR,
        ST_R,
        ST_AW_W,
        ST_B
    } state_t;

    function automatic logic in_group(input logic [7:0] c, input logic [7:0] base);
        return c >= base && c <= base + 8'd3;
    endfunction

endpackage

// File: rtl/uart_probe.sv
// uart_probe: byte-command debug probe giving a UART byte stream access to GPI/GPO and
// single-byte AXI reads and writes through an internal address register.
module uart_probe
    import uart_probe_pkg::*;
(
    input  logic        clk,
    input  logic        m_aresetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] gpo,
    input  logic [31:0] gpi,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arsize,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awsize,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid
);

    state_t      state;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic        auto_inc;
    logic [1:0]  last_resp;
    logic [7:0]  wbyte;
    logic        accept;
    logic [1:0]  rx_idx;
    logic [1:0]  cmd_idx;
    logic [7:0]  ctrl_byte;
    logic [7:0]  rd_byte;
    logic        is_rd;
    logic        is_arg;
    logic        aw_done;
    logic        w_done;
    logic [31:0] addr_next;

    // Every byte-indexed group starts at a code == 2 (mod 4), so the lane is code + 2 mod 4.
    assign rx_idx    = rx_data[1:0] + 2'd2;
    assign cmd_idx   = cmd[1:0] + 2'd2;
    assign accept    = rx_valid && rx_ready;
    assign addr_next = auto_inc ? addr + 32'd1 : addr;
    assign aw_done   = !m_axi_awvalid || m_axi_awready;
    assign w_done    = !m_axi_wvalid || m_axi_wready;

    always_comb begin
        ctrl_byte = 8'd0;
        ctrl_byte[CTRL_AUTO_INC] = auto_inc;
        ctrl_byte[CTRL_RESP_HI:CTRL_RESP_LO] = last_resp;
        is_rd = in_group(rx_data, CMD_GPI_RD0) || in_group(rx_data, CMD_GPO_RD0) ||
                in_group(rx_data, CMD_AXI_RD0) || rx_data == CMD_AXI_RDC;
        is_arg = in_group(rx_data, CMD_GPO_WR0) || in_group(rx_data, CMD_AXI_WR0) ||
                 rx_data == CMD_AXI_WR || rx_data == CMD_AXI_WRC;
        rd_byte = in_group(rx_data, CMD_GPI_RD0) ? gpi[8*rx_idx +: 8] :
                  in_group(rx_data, CMD_GPO_RD0) ? gpo[8*rx_idx +: 8] :
                  in_group(rx_data, CMD_AXI_RD0) ? addr[8*rx_idx +: 8] : ctrl_byte;
    end

    assign m_axi_araddr = addr;
    assign m_axi_arsize = 3'd0;
    assign m_axi_awaddr = addr;
    assign m_axi_awsize = 3'd0;
    assign m_axi_wdata  = {4{wbyte}};
    assign m_axi_wstrb  = 4'b0001 << addr[1:0];

    always_ff @(posedge clk) begin
        if (m_aresetn) begin
            state         <= ST_IDLE;
            cmd           <= 8'd0;
            addr          <= 32'd0;
            auto_inc      <= 1'b0;
            last_resp     <= 2'd0;
            wbyte         <= 8'd0;
            gpo           <= 32'd0;
            rx_ready      <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= 8'd0;
            m_axi_arvalid <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rx_ready <= 1'b1;
                    if (accept) begin
                        cmd <= rx_data;
                        if (is_rd) begin
                            tx_data  <= rd_byte;
                            tx_valid <= 1'b1;
                            rx_ready <= 1'b0;
                            state    <= ST_RESP;
                        end else if (is_arg) begin
                            state <= ST_ARG;
                        end else if (rx_data == CMD_AXI_RD) begin
                            m_axi_arvalid <= 1'b1;
                            rx_ready      <= 1'b0;
                            state         <= ST_AR;
                        end
                    end
                end
                ST_ARG: begin
                    if (accept) begin
                        state <= ST_IDLE;
                        if (in_group(cmd, CMD_GPO_WR0)) gpo[8*cmd_idx +: 8] <= rx_data;
                        if (in_group(cmd, CMD_AXI_WR0)) addr[8*cmd_idx +: 8] <= rx_data;
                        if (cmd == CMD_AXI_WRC) auto_inc <= rx_data[CTRL_AUTO_INC];
                        if (cmd == CMD_AXI_WR) begin
                            wbyte         <= rx_data;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            rx_ready      <= 1'b0;
                            state         <= ST_AW_W;
                        end
                    end
                end
                ST_RESP: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        rx_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        last_resp    <= m_axi_rresp;
                        tx_data      <= m_axi_rdata[8*addr[1:0] +: 8];
                        tx_valid     <= 1'b1;
                        addr         <= addr_next;
                        state        <= ST_RESP;
                    end
                end
                ST_AW_W: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready) m_axi_wvalid <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_B;
                    end
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        last_resp    <= m_axi_bresp;
                        addr         <= addr_next;
                        rx_ready     <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_probe.sv
// tb_uart_probe: directed checks of the uart_probe command set, AXI handshakes and reset abort.
module tb_uart_probe;

    logic        clk = 1'b0;
    logic        m_aresetn = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic [31:0] gpo;
    logic [31:0] gpi = 32'd0;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arsize;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awsize;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic        m_axi_bready;
    logic [1:0]  m_axi_bresp = 2'd0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_rready;
    logic [31:0] m_axi_rdata = 32'd0;
    logic [1:0]  m_axi_rresp = 2'd0;
    logic        m_axi_rvalid = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_probe dut (
        .clk(clk), .m_aresetn(m_aresetn),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .gpo(gpo), .gpi(gpi),
        .m_axi_araddr(m_axi_araddr), .m_axi_arsize(m_axi_arsize),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awsize(m_axi_awsize),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp);
        int n = 0;
        logic [7:0] d;
        @(negedge clk);
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
        d = tx_data;
        tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
        chk(tag, {24'd0, d}, {24'd0, exp});
        chk({tag, "_drop"}, {31'd0, tx_valid}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_axi_valids", {27'd0, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_rready}, 32'd0);
        chk("rst_gpo", gpo, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        m_aresetn = 1'b0;
        @(negedge clk);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

        send_byte(8'd10);
        send_byte(8'hAB);
        chk("gpo_wr0", gpo, 32'h0000_00AB);
        send_byte(8'd6);
        expect_tx("gpo_rd0", 8'hAB);

        gpi = 32'h1234_5678;
        send_byte(8'd2);
        expect_tx("gpi_rd0", 8'h78);
        send_byte(8'd3);
        expect_tx("gpi_rd1", 8'h56);
        send_byte(8'd4);
        expect_tx("gpi_rd2", 8'h34);
        send_byte(8'd5);
        expect_tx("gpi_rd3", 8'h12);

        send_byte(8'd18); send_byte(8'h03);
        send_byte(8'd19); send_byte(8'h20);
        send_byte(8'd20); send_byte(8'h00);
        send_byte(8'd21); send_byte(8'h40);
        send_byte(8'd14);
        expect_tx("addr_rd0", 8'h03);
        send_byte(8'd15);
        expect_tx("addr_rd1", 8'h20);
        send_byte(8'd16);
        expect_tx("addr_rd2", 8'h00);
        send_byte(8'd17);
        expect_tx("addr_rd3", 8'h40);

        send_byte(8'd22);
        chk("ar_valid", {31'd0, m_axi_arvalid}, 32'd1);
        chk("ar_addr", m_axi_araddr, 32'h4000_2003);
        chk("ar_size", {29'd0, m_axi_arsize}, 32'd0);
        chk("ar_no_rx", {31'd0, rx_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("ar_held", {31'd0, m_axi_arvalid}, 32'd1);
        m_axi_arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_axi_arready = 1'b0;
        chk("ar_drop", {31'd0, m_axi_arvalid}, 32'd0);
        chk("r_ready", {31'd0, m_axi_rready}, 32'd1);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'hDEAD_BEEF;
        m_axi_rresp  = 2'd0;
        @(posedge clk);
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        chk("r_ready_drop", {31'd0, m_axi_rready}, 32'd0);
        expect_tx("axi_rd", 8'hDE);
        send_byte(8'd24);
        expect_tx("ctrl_after_rd", 8'h00);

        send_byte(8'd25); send_byte(8'h01);
        send_byte(8'd18); send_byte(8'h10);
        send_byte(8'd19); send_byte(8'h00);
        send_byte(8'd20); send_byte(8'h00);
        send_byte(8'd21); send_byte(8'h00);
        send_byte(8'd23);
        send_byte(8'h5A);
        chk("aw_valid", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
        chk("aw_addr", m_axi_awaddr, 32'h0000_0010);
        chk("aw_size", {29'd0, m_axi_awsize}, 32'd0);
        chk("w_data", m_axi_wdata, 32'h5A5A_5A5A);
        chk("w_strb", {28'd0, m_axi_wstrb}, 32'b0001);
        m_axi_awready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_axi_awready = 1'b0;
        chk("aw_only_done", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd1);
        chk("b_not_yet", {31'd0, m_axi_bready}, 32'd0);
        m_axi_wready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_axi_wready = 1'b0;
        chk("w_done", {31'd0, m_axi_wvalid}, 32'd0);
        chk("b_ready", {31'd0, m_axi_bready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("b_wait", {31'd0, m_axi_bready}, 32'd1);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'd2;
        @(posedge clk);
        @(negedge clk);
        m_axi_bvalid = 1'b0;
        chk("b_ready_drop", {31'd0, m_axi_bready}, 32'd0);
        send_byte(8'd14);
        expect_tx("addr_inc", 8'h11);
        send_byte(8'd24);
        expect_tx("ctrl_slverr", 8'h09);

        send_byte(8'd23);
        send_byte(8'h77);
        chk("w2_data", m_axi_wdata, 32'h7777_7777);
        chk("w2_strb", {28'd0, m_axi_wstrb}, 32'b0010);
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        chk("w2_both_done", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'd1);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'd0;
        @(posedge clk);
        @(negedge clk);
        m_axi_bvalid = 1'b0;
        send_byte(8'd14);
        expect_tx("addr_inc2", 8'h12);
        send_byte(8'd24);
        expect_tx("ctrl_okay", 8'h01);

        send_byte(8'h00);
        chk("unk00_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'hFF);
        repeat (3) @(negedge clk);
        chk("unk_no_tx", {31'd0, tx_valid}, 32'd0);
        chk("unkff_rx_ready", {31'd0, rx_ready}, 32'd1);

        send_byte(8'd22);
        chk("ar2_valid", {31'd0, m_axi_arvalid}, 32'd1);
        chk("gpo_before_rst", gpo, 32'h0000_00AB);
        m_aresetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_abort_ar", {31'd0, m_axi_arvalid}, 32'd0);
        chk("rst_abort_gpo", gpo, 32'd0);
        chk("rst_abort_rx", {31'd0, rx_ready}, 32'd0);
        m_aresetn = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, rx_ready}, 32'd1);
        send_byte(8'd14);
        expect_tx("post_rst_addr", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_probe.md
# uart_probe

Byte-stream debug probe between a UART byte interface and the SoC. It decodes single-byte commands from the RX stream to read a 32-bit GPI port, read/write a 32-bit GPO register, and issue single-byte AXI read/write transactions through an internal address register. Responses return as bytes on the TX stream.

## Interface
- No parameters. Address, data and GPIO widths are fixed at 32.
- `clk` input 1: sole clock, rising edge.
- `m_aresetn` input 1: synchronous, active-high reset. The name is kept for compatibility; the polarity is high.
- `rx_valid` / `rx_data[7:0]` / `rx_ready` in/in/out: command byte stream. A byte is accepted on a clock edge with `rx_valid && rx_ready`.
- `tx_valid` / `tx_data[7:0]` / `tx_ready` out/out/in: response stream. A byte transfers on `tx_valid && tx_ready`.
- `gpo` output 32: general-purpose output register.
- `gpi` input 32: general-purpose inputs.
- `m_axi_ar{addr[31:0],size[2:0],valid}` out, `m_axi_arready` in.
- `m_axi_aw{addr[31:0],size[2:0],valid}` out, `m_axi_awready` in.
- `m_axi_w{data[31:0],strb[3:0],valid}` out, `m_axi_wready` in.
- `m_axi_bready` out, `m_axi_bresp[1:0]`/`m_axi_bvalid` in.
- `m_axi_rready` out, `m_axi_rdata[31:0]`/`m_axi_rresp[1:0]`/`m_axi_rvalid` in.

## Operation
- Command codes, with n = byte index 0..3 and byte n = bits [8n+7:8n]:
  - 2–5 GPI_RDn: respond with gpi byte n.
  - 6–9 GPO_RDn: respond with gpo byte n.
  - 10–13 GPO_WRn: the next RX byte is written to gpo byte n. No response.
  - 14–17 AXI_RDn: respond with address register byte n.
  - 18–21 AXI_WRn: the next RX byte is written to address byte n.
  - 22 AXI_RD: byte read at the address, then respond with the data byte.
  - 23 AXI_WR: the next RX byte is the data. Byte write at the address. No response.
  - 24 AXI_RDC: respond with the control register.
  - 25 AXI_WRC: the next RX byte is written to the control register.
- Any other code is silently discarded and the block stays in IDLE.
- Control register:
  - bit0 auto-increment: address += 1 after each AXI_RD/AXI_WR completes. The address wraps 0xFFFFFFFF -> 0.
  - bits[3:2]: read-only, last rresp/bresp.
  - Other bits are reserved and read 0. WRC writes only bit0.
- AXI reads:
  - araddr = address, arsize = 0.
  - Response byte = rdata byte lane addr[1:0].
- AXI writes:
  - awaddr = address, awsize = 0.
  - wdata = data byte replicated on all four lanes.
  - wstrb = one-hot of addr[1:0].
- State machine:
  - IDLE -> (argument command) ARG -> IDLE.
  - IDLE -> RESP -> IDLE, for read commands.
  - AXI_RD: IDLE -> AR -> R -> RESP.
  - AXI_WR: IDLE -> ARG -> AW_W -> B -> IDLE.
- Only one command is in flight at a time.

## Timing
- Reset values:
  - tx_valid, rx_ready, all AXI valids, bready and rready = 0.
  - gpo, address and control = 0.
  - tx_data = 0.
- rx_ready is 1 only in IDLE and ARG.
- GPI/GPO/register reads:
  - The value is sampled at the accept edge.
  - tx_valid rises on the following cycle.
  - tx_valid and tx_data are held stable until tx_ready; tx_valid drops the cycle after the transfer.
- Register writes take effect on the edge that accepts the argument byte. gpo updates that cycle.
- AR: arvalid is held until arready.
- R: rready = 1 until rvalid; rdata and rresp are captured on that edge.
- AW_W:
  - awvalid and wvalid are asserted together.
  - Each drops independently on its ready.
  - The block leaves AW_W when both have handshaken, including when they handshake in the same cycle.
- B: bready = 1 until bvalid; bresp is captured.
- There is no AXI timeout; the probe waits indefinitely.
- Reset mid-operation aborts all valids on the next edge and returns to IDLE. A partial AXI transaction is abandoned.

## Structure
- Shared package `uart_probe_pkg`: the 24 command code constants, state enum, and control bit indices.
- A single module is sufficient; no sub-module is required.

## Test plan
- Reset; GPO_WR0 then 0xAB; GPO_RD0 -> gpo[7:0]=0xAB, TX byte 0xAB, other gpo bytes remain 0.
- gpi=0x12345678; GPI_RD0..3 -> TX bytes 0x78, 0x56, 0x34, 0x12.
- AXI_WR0..3 with 0x03, 0x20, 0x00, 0x40; AXI_RD0..3 -> 0x03, 0x20, 0x00, 0x40.
- AXI read scenario:
  - Address 0x40002003; the slave delays arready 2 cycles and returns rdata 0xDEADBEEF with rresp=0.
  - araddr=0x40002003, arsize=0.
  - TX byte 0xDE.
  - Then AXI_RDC -> 0x00.
- AXI write scenario:
  - Set ctrl=0x01, address 0x10, send AXI_WR, 0x5A.
  - Required AXI outputs: awaddr=0x10, wdata=0x5A5A5A5A, wstrb=0001.
  - Slave returns bresp=2 (SLVERR) with bvalid delayed 3 cycles.
  - AXI_RD0 -> 0x11, AXI_RDC -> 0x09.
- Unknown command 0x00 / 0xFF -> no TX byte, rx_ready stays 1.
- Assert reset during AR wait -> arvalid=0 next cycle, gpo=0.
